// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin sharing of one 4x4 array multiplier among NREQ requesters.
// Define MULT_SHARE_ARB_STATS_EN to add the grant_cnt / stall_cnt statistics outputs.

module fbf_mult_7 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);
   logic [7:0] row [4];
   logic [7:0] acc [5];

   assign acc[0] = 8'd0;

   // One shifted partial-product row per multiplier bit, accumulated down the array.
   for (genvar gi = 0; gi < 4; gi++) begin : g_row
      assign row[gi]    = {4'd0, a & {4{b[gi]}}} << gi;
      assign acc[gi+1]  = acc[gi] + row[gi];
   end

   assign p = acc[4];
endmodule

module mult_share_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [4*NREQ-1:0] req_a,
   input  logic [4*NREQ-1:0] req_b,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [7:0]        res_p,
   output logic [IDW-1:0]    res_id,
   output logic              busy
`ifdef MULT_SHARE_ARB_STATS_EN
   ,
   output logic [15:0]       grant_cnt,
   output logic [15:0]       stall_cnt
`endif
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [3:0]     a_q, a_d;
   logic [3:0]     b_q, b_d;
   logic [IDW-1:0] id_q, id_d;
   logic [7:0]     res_p_q, res_p_d;
   logic [IDW-1:0] res_id_q, res_id_d;
   logic           res_valid_q, res_valid_d;

   logic [3:0]     a_arr [NREQ];
   logic [3:0]     b_arr [NREQ];
   logic [IDW-1:0] cand  [NREQ];
   logic           gnt_found;
   logic [IDW-1:0] gnt_idx;
   logic           take;
   logic [7:0]     mult_p;

   // cand[k] is the requester visited k-th in the search starting at ptr.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [IDW:0] sum;
      assign sum       = {1'b0, ptr_q} + (IDW+1)'(gi);
      assign cand[gi]  = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];
      assign a_arr[gi] = req_a[4*gi +: 4];
      assign b_arr[gi] = req_b[4*gi +: 4];
   end

   // Walk from the far end so the candidate closest to ptr wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid[cand[k]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[k];
         end
      end
   end

   fbf_mult_7 u_mult (
      .a (a_q),
      .b (b_q),
      .p (mult_p)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      res_p_d     = res_p_q;
      res_id_d    = res_id_q;
      res_valid_d = res_valid_q;
      take        = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_found) begin
               take    = 1'b1;
               a_d     = a_arr[gnt_idx];
               b_d     = b_arr[gnt_idx];
               id_d    = gnt_idx;
               ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
               state_d = EXEC;
            end
         end
         EXEC: begin
            res_p_d     = mult_p;
            res_id_d    = id_q;
            res_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         res_p_q     <= '0;
         res_id_q    <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         res_p_q     <= res_p_d;
         res_id_q    <= res_id_d;
         res_valid_q <= res_valid_d;
      end
   end

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = take && !rst && (gnt_idx == IDW'(gi));
   end

   assign res_valid = res_valid_q;
   assign res_p     = res_p_q;
   assign res_id    = res_id_q;
   assign busy      = (state_q != IDLE);

`ifdef MULT_SHARE_ARB_STATS_EN
   logic [15:0] grant_cnt_q, grant_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // grant_cnt wraps naturally; stall_cnt sticks at all-ones.
   always_comb begin
      grant_cnt_d = grant_cnt_q + (take ? 16'd1 : 16'd0);
      stall_cnt_d = stall_cnt_q;
      if (state_q == RESP && !res_ready && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         grant_cnt_q <= grant_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign grant_cnt = grant_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_mult_share_arb.sv
// Scoreboard bench for mult_share_arb: stimulus pushes expected grants/results, a monitor pops and compares.
// Build with MULT_SHARE_ARB_STATS_EN defined to also check the statistics counters.

module tb_mult_share_arb;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [4*NREQ-1:0] req_a;
   logic [4*NREQ-1:0] req_b;
   logic              res_valid;
   logic              res_ready;
   logic [7:0]        res_p;
   logic [IDW-1:0]    res_id;
   logic              busy;
`ifdef MULT_SHARE_ARB_STATS_EN
   logic [15:0]       grant_cnt;
   logic [15:0]       stall_cnt;
`endif

   mult_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_p     (res_p),
      .res_id    (res_id),
`ifdef MULT_SHARE_ARB_STATS_EN
      .grant_cnt (grant_cnt),
      .stall_cnt (stall_cnt),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         exp_gnt [$];
   logic [9:0] exp_res [$];
   int         gnt_seen = 0;
   int         gnt_model = 0;
   int         last_gnt_cyc = 0;
   logic       prev_valid = 1'b0;
   logic       prev_taken = 1'b0;
   logic [7:0] held_p = '0;
   logic [IDW-1:0] held_id = '0;
   int         mon_e;
   logic [9:0] mon_r;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: grants and results compared against the queues filled by the stimulus.
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
         prev_taken = 1'b0;
         gnt_model  = 0;
         if (req_valid != '0) check("ready_in_reset", int'(req_ready), 0);
      end else begin
         if (busy) begin
            check("ready_outside_idle", int'(req_ready), 0);
         end else if (req_ready != '0) begin
            gnt_seen++;
            gnt_model++;
            last_gnt_cyc = cyc;
            if (exp_gnt.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_grant: got ready=%b expected none", req_ready);
            end else begin
               mon_e = exp_gnt.pop_front();
               check("grant", int'(req_ready), 1 << mon_e);
            end
         end
         if (res_valid && !prev_valid) check("latency", cyc - last_gnt_cyc, 2);
         if (res_valid && prev_valid && !prev_taken) begin
            check("hold_p", int'(res_p), int'(held_p));
            check("hold_id", int'(res_id), int'(held_id));
         end
         if (res_valid && res_ready) begin
            if (exp_res.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got p=%0d id=%0d expected none", res_p, res_id);
            end else begin
               mon_r = exp_res.pop_front();
               check("res_p", int'(res_p), int'(mon_r[7:0]));
               check("res_id", int'(res_id), int'(mon_r[9:8]));
               $display("result id=%0d p=%0d (cycle %0d)", res_id, res_p, cyc);
            end
         end
         prev_valid = res_valid;
         prev_taken = res_valid && res_ready;
         held_p     = res_p;
         held_id    = res_id;
      end
   end

   task automatic wait_grants(input int n);
      int target;
      int t;
      target = gnt_seen + n;
      t = 0;
      while (gnt_seen < target && t < 100) begin
         @(posedge clk);
         t++;
      end
      if (gnt_seen < target) begin
         checks++;
         errors++;
         $display("FAIL grant_timeout: got %0d grants expected %0d", gnt_seen, target);
      end
      #1;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      do begin
         @(posedge clk);
         #1;
         t++;
      end while ((exp_res.size() != 0 || exp_gnt.size() != 0 || busy) && t < 200);
      if (exp_res.size() != 0 || exp_gnt.size() != 0 || busy) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d results %0d grants pending expected 0",
                  exp_res.size(), exp_gnt.size());
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_res_valid"}, int'(res_valid), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_res_p"}, int'(res_p), 0);
      check({tag, "_res_id"}, int'(res_id), 0);
      check({tag, "_req_ready"}, int'(req_ready), 0);
`ifdef MULT_SHARE_ARB_STATS_EN
      check({tag, "_grant_cnt"}, int'(grant_cnt), 0);
      check({tag, "_stall_cnt"}, int'(stall_cnt), 0);
`endif
   endtask

   initial begin
      int t;
      rst       = 1'b1;
      req_valid = 4'b1111;
      req_a     = '0;
      req_b     = '0;
      res_ready = 1'b1;

      // Reset with requests pending, then idle.
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      req_valid = '0;
      check_reset_state("reset");
      repeat (5) begin
         @(negedge clk);
         check("idle_busy", int'(busy), 0);
         check("idle_res_valid", int'(res_valid), 0);
         check("idle_req_ready", int'(req_ready), 0);
      end
      @(posedge clk);
      #1;

      // Single request 3*5 with exact cycle timing.
      req_a[3:0] = 4'd3;
      req_b[3:0] = 4'd5;
      exp_gnt.push_back(0);
      exp_res.push_back({2'd0, 8'd15});
      req_valid = 4'b0001;
      wait_grants(1);
      req_valid = '0;
      check("single_exec_busy", int'(busy), 1);
      @(posedge clk);
      #1 check("single_resp_valid", int'(res_valid), 1);
      @(posedge clk);
      #1 check("single_back_idle", int'(busy), 0);
      wait_drain();

      // Round robin with all four requesters holding valid.
      do_reset();
      req_a = {4'd7, 4'd15, 4'd2, 4'd1};
      req_b = {4'd9, 4'd15, 4'd3, 4'd1};
      exp_gnt.push_back(0); exp_res.push_back({2'd0, 8'd1});
      exp_gnt.push_back(1); exp_res.push_back({2'd1, 8'd6});
      exp_gnt.push_back(2); exp_res.push_back({2'd2, 8'd225});
      exp_gnt.push_back(3); exp_res.push_back({2'd3, 8'd63});
      exp_gnt.push_back(0); exp_res.push_back({2'd0, 8'd1});
      req_valid = 4'b1111;
      wait_grants(5);
      req_valid = '0;
      wait_drain();

      // Backpressure: 12*11 held for 6 stalled cycles; requester 0 waits meanwhile.
      do_reset();
      res_ready   = 1'b0;
      req_a[11:8] = 4'd12;
      req_b[11:8] = 4'd11;
      exp_gnt.push_back(2);
      exp_res.push_back({2'd2, 8'd132});
      req_valid = 4'b0100;
      wait_grants(1);
      req_valid = '0;
      t = 0;
      while (!res_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("bp_res_valid_seen", int'(res_valid), 1);
      req_a[3:0] = 4'd1;
      req_b[3:0] = 4'd1;
      exp_gnt.push_back(0);
      exp_res.push_back({2'd0, 8'd1});
      req_valid = 4'b0001;
      repeat (6) @(posedge clk);
      #1 res_ready = 1'b1;
      wait_grants(1);
      req_valid = '0;
      wait_drain();
`ifdef MULT_SHARE_ARB_STATS_EN
      check("stall_cnt", int'(stall_cnt), 6);
      check("grant_cnt", int'(grant_cnt), gnt_model);
      check("grant_cnt_two", int'(grant_cnt), 2);
`endif

      // Operands change after accept must not affect the result.
      req_a[7:4] = 4'd4;
      req_b[7:4] = 4'd4;
      exp_gnt.push_back(1);
      exp_res.push_back({2'd1, 8'd16});
      req_valid = 4'b0010;
      wait_grants(1);
      req_valid  = '0;
      req_a[7:4] = 4'd9;
      req_b[7:4] = 4'd9;
      wait_drain();

      // Reset during EXEC drops the operation; pointer restarts at 0.
      req_a[11:8] = 4'd5;
      req_b[11:8] = 4'd5;
      exp_gnt.push_back(2);
      req_valid = 4'b0100;
      wait_grants(1);
      req_valid = '0;
      check("midop_in_exec", int'(busy), 1);
      do_reset();
      check_reset_state("midop");
      req_a[3:0]   = 4'd2;
      req_b[3:0]   = 4'd2;
      req_a[15:12] = 4'd1;
      req_b[15:12] = 4'd7;
      exp_gnt.push_back(0); exp_res.push_back({2'd0, 8'd4});
      exp_gnt.push_back(3); exp_res.push_back({2'd3, 8'd7});
      req_valid = 4'b1001;
      wait_grants(1);
      req_valid = 4'b1000;
      wait_grants(1);
      req_valid = '0;
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
